// File: rtl/proto_abc_responder.sv
// proto_abc_responder
//   Responder end of the single-clock a/b/c request protocol (a |-> b ##1 c).
//   A request (a = req_i) is acknowledged in the same cycle (b = ack_o).
//   Exactly one cycle later a response strobe (c = rsp_valid_o) carries the
//   processed payload. The block also flags protocol violations with a sticky
//   error and counts completed responses, saturating at all-ones.
//
//   Optional feature: define PROTO_ABC_CHK_EN to compile the built-in
//   protocol assertions and the back-to-back cover property. Functional
//   behaviour is identical with or without the macro.
//
// Ports
//   clk          in   clock, all state updates on posedge
//   rst_n        in   asynchronous active-low reset
//   req_i        in   request strobe (a)
//   req_op_i     in   [1:0] operation, sampled with req_i
//   req_data_i   in   [DATA_W-1:0] payload, sampled with req_i
//   hold_i       in   when high the block is not ready
//   clear_i      in   clears the sticky error state
//   ready_o      out  block can accept a request this cycle
//   ack_o        out  (b) req_i & ready_o, combinational
//   rsp_valid_o  out  (c) one-cycle response strobe
//   rsp_data_o   out  [DATA_W-1:0] result, holds when rsp_valid_o is low
//   err_o        out  sticky protocol-error flag
//   txn_cnt_o    out  [CNT_W-1:0] completed-response count, saturating
module proto_abc_responder #(
    parameter int                DATA_W  = 8,
    parameter int                CNT_W   = 16,
    parameter logic [DATA_W-1:0] XOR_KEY = DATA_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic [1:0]        req_op_i,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic              hold_i,
    input  logic              clear_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  txn_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        ERR  = 2'b10
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic [DATA_W-1:0] rsp_data_next;
    logic [CNT_W-1:0]  txn_cnt_reg;
    logic              ready;
    logic              ack;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            txn_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            rsp_valid_reg <= ack;
            if (ack) begin
                rsp_data_reg <= rsp_data_next;
                if (txn_cnt_reg != CNT_MAX) begin
                    txn_cnt_reg <= txn_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        ready         = 1'b0;
        ack           = 1'b0;
        state_next    = state_reg;
        rsp_data_next = req_data_i;

        ready = !hold_i && (state_reg != ERR);
        ack   = req_i && ready;

        unique case (req_op_i)
            2'b00:   rsp_data_next = req_data_i;
            2'b01:   rsp_data_next = ~req_data_i;
            2'b10:   rsp_data_next = req_data_i + DATA_W'(1);
            default: rsp_data_next = req_data_i ^ XOR_KEY;
        endcase

        case (state_reg)
            ERR: begin
                // Requests are ignored here; a request together with clear_i
                // is neither served nor treated as a new violation.
                if (clear_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                // A violation wins over everything; any response already
                // registered from the previous cycle still issues regardless.
                if (req_i && !ready) begin
                    state_next = ERR;
                end else if (ack) begin
                    state_next = BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    assign ready_o     = ready;
    assign ack_o       = ack;
    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_data_o  = rsp_data_reg;
    assign err_o       = (state_reg == ERR);
    assign txn_cnt_o   = txn_cnt_reg;

`ifdef PROTO_ABC_CHK_EN
    a_req_ack_rsp : assert property (@(posedge clk) disable iff (!rst_n)
        (req_i && ready_o) |-> ack_o ##1 rsp_valid_o);

    a_rsp_has_ack : assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid_o |-> $past(ack_o));

    a_err_not_ready : assert property (@(posedge clk) disable iff (!rst_n)
        err_o |-> !ready_o);

    c_back_to_back : cover property (@(posedge clk) disable iff (!rst_n)
        req_i ##1 req_i);
`else
`endif

endmodule

// File: tb/tb_proto_abc_responder.sv
// Testbench for proto_abc_responder: directed steps followed by randomized
// traffic, checked against a transaction-level reference model. A second
// instance with CNT_W = 2 shares the stimulus to exercise counter saturation.
module tb_proto_abc_responder;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [1:0] op;
    logic [7:0] data;
    logic       hold;
    logic       clear;

    logic        ready, ack, rsp_valid, err;
    logic [7:0]  rsp_data;
    logic [15:0] txn_cnt;

    logic        ready2, ack2, rsp_valid2, err2;
    logic [7:0]  rsp_data2;
    logic [1:0]  txn_cnt2;

    int vectors;
    int miscompares;

    // Reference model: error flag, last response, completed-response counts.
    logic        m_err;
    logic        m_valid;
    logic [7:0]  m_data;
    int          m_cnt;
    int          m_cnt2;

    proto_abc_responder #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .req_op_i(op), .req_data_i(data),
        .hold_i(hold), .clear_i(clear), .ready_o(ready), .ack_o(ack),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .err_o(err),
        .txn_cnt_o(txn_cnt)
    );

    proto_abc_responder #(.DATA_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_i(req), .req_op_i(op), .req_data_i(data),
        .hold_i(hold), .clear_i(clear), .ready_o(ready2), .ack_o(ack2),
        .rsp_valid_o(rsp_valid2), .rsp_data_o(rsp_data2), .err_o(err2),
        .txn_cnt_o(txn_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_f(input logic [1:0] o, input logic [7:0] d);
        case (o)
            2'b00:   return d;
            2'b01:   return ~d;
            2'b10:   return 8'((int'(d) + 1) % 256);
            default: return d ^ 8'hA5;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_err   = 1'b0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_cnt   = 0;
        m_cnt2  = 0;
    endtask

    task automatic check_outputs(input string where);
        check({where, ".rsp_valid"}, rsp_valid, m_valid);
        check({where, ".rsp_data"},  rsp_data,  m_data);
        check({where, ".err"},       err,       m_err);
        check({where, ".txn_cnt"},   txn_cnt,   m_cnt);
        check({where, ".txn_cnt2"},  txn_cnt2,  m_cnt2);
    endtask

    // One clock cycle: drive inputs, check combinational ready/ack, then
    // advance the model across the edge and check registered outputs.
    task automatic step(input logic r, input logic [1:0] o, input logic [7:0] d,
                        input logic h, input logic c);
        logic exp_ready, exp_ack;
        @(negedge clk);
        req = r; op = o; data = d; hold = h; clear = c;
        #1;
        exp_ready = !h && !m_err;
        exp_ack   = r && exp_ready;
        check("ready", ready, exp_ready);
        check("ack",   ack,   exp_ack);
        @(posedge clk);
        #1;
        m_valid = exp_ack;
        if (exp_ack) begin
            m_data = ref_f(o, d);
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3)    m_cnt2++;
        end
        if (m_err) begin
            if (c) m_err = 1'b0;
        end else if (r && h) begin
            m_err = 1'b1;
        end
        check_outputs("edge");
        $display("txn req=%0b op=%0b data=%02h hold=%0b clear=%0b -> rsp_valid=%0b rsp_data=%02h err=%0b cnt=%0d",
                 r, o, d, h, c, rsp_valid, rsp_data, err, txn_cnt);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        req = 1'b0; op = 2'b00; data = 8'h00; hold = 1'b0; clear = 1'b0;
        model_reset();

        // Reset state
        #3;
        check_outputs("reset");
        check("reset.ready", ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, op 00
        step(1'b1, 2'b00, 8'h3C, 1'b0, 1'b0);
        check("single.data", rsp_data, 8'h3C);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0);

        // Back-to-back ops 10/01/11/00 on 8'hFF
        step(1'b1, 2'b10, 8'hFF, 1'b0, 1'b0);
        check("b2b.inc_wrap", rsp_data, 8'h00);
        step(1'b1, 2'b01, 8'hFF, 1'b0, 1'b0);
        check("b2b.not", rsp_data, 8'h00);
        step(1'b1, 2'b11, 8'hFF, 1'b0, 1'b0);
        check("b2b.xor", rsp_data, 8'h5A);
        step(1'b1, 2'b00, 8'hFF, 1'b0, 1'b0);
        check("b2b.pass", rsp_data, 8'hFF);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0);

        // Violation, ignored request in ERR, then clear
        step(1'b1, 2'b00, 8'h11, 1'b1, 1'b0);
        step(1'b1, 2'b01, 8'h22, 1'b0, 1'b0);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0);

        // Clear together with a request while in ERR
        step(1'b1, 2'b00, 8'h33, 1'b1, 1'b0);
        step(1'b1, 2'b10, 8'h44, 1'b0, 1'b1);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0);

        // Violation in the cycle a previous response issues
        step(1'b1, 2'b11, 8'h0F, 1'b0, 1'b0);
        step(1'b1, 2'b00, 8'h77, 1'b1, 1'b0);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0);

        // Accepted request followed by a mid-cycle asynchronous reset
        @(negedge clk);
        req = 1'b1; op = 2'b01; data = 8'h55; hold = 1'b0; clear = 1'b0;
        #1;
        check("rstmid.ack", ack, 1'b1);
        #1;
        rst_n = 1'b0;
        req = 1'b0;
        #1;
        model_reset();
        check_outputs("rstmid.async");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("rstmid.edge");

        // Five requests: saturating counter on the CNT_W = 2 instance
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'(i), 8'(i * 37), 1'b0, 1'b0);
        end
        check("sat.cnt2", txn_cnt2, 2'd3);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
